// File: rtl/recip_sched.sv
// Shared reciprocal scheduler: round-robin grant of one 17-step restoring divider
// computing min(65536/denom, 2047) to two requesters. Optional per-port cache: RECIP_SCHED_CACHE_EN.

`ifdef RECIP_SCHED_CACHE_EN
module recip_sched_centry #(
  parameter int DW = 10,
  parameter int QW = 11
) (
  input  logic          clk48,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wden,
  input  logic [QW-1:0] wres,
  output logic          vld,
  output logic [DW-1:0] den,
  output logic [QW-1:0] res
);
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      den <= '0;
      res <= '0;
    end else if (wr) begin
      vld <= 1'b1;
      den <= wden;
      res <= wres;
    end
  end
endmodule
`endif

module recip_sched #(
  parameter int QW = 11,
  parameter int DW = 10
) (
  input  logic          clk48,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [DW-1:0] denom0,
  input  logic [DW-1:0] denom1,
  output logic [1:0]    ack,
  output logic [1:0]    done,
  output logic [QW-1:0] result,
  output logic          busy
);
  localparam int NP = 2;
  localparam int QB = 17;
  localparam logic [QW-1:0] SAT = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic          last;
  logic [4:0]    cnt;
  logic [QB-1:0] quo;
  logic [DW:0]   rem;
  logic          owner;
  logic [DW-1:0] den_q;

  logic          gnt_vld, pick, zero_den, hit, owner_nx;
  logic [1:0]    gnt_oh;
  logic [DW-1:0] den_sel;
  logic [QW-1:0] hit_res, sat_res, fin_res;

  // Round robin: on a tie the port not granted last time wins.
  assign gnt_vld  = (state != RUN) && (|req);
  assign pick     = (&req) ? ~last : req[1];
  assign gnt_oh   = pick ? 2'b10 : 2'b01;
  assign den_sel  = pick ? denom1 : denom0;
  assign zero_den = (den_sel == '0);
  assign owner_nx = gnt_vld ? pick : owner;
  assign ack      = (gnt_vld && rst_n) ? gnt_oh : 2'b00;
  assign busy     = (state == RUN);

  // One restoring step; the dividend 2^16 contributes a single 1 on the first step.
  logic [DW:0]   trial;
  logic          ge;
  logic [DW:0]   rem_nx;
  logic [QB-1:0] quo_nx;

  assign trial   = {rem[DW-1:0], (cnt == 5'd0)};
  assign ge      = rem[DW] | (trial >= {1'b0, den_q});
  assign rem_nx  = ge ? (trial - {1'b0, den_q}) : trial;
  assign quo_nx  = {quo[QB-2:0], ge};
  assign sat_res = ((|quo_nx[QB-1:QW]) | quo[QB-1]) ? SAT : quo_nx[QW-1:0];

`ifdef RECIP_SCHED_CACHE_EN
  logic [NP-1:0]         c_vld;
  logic [NP-1:0][DW-1:0] c_den;
  logic [NP-1:0][QW-1:0] c_res;
  logic                  byp;

  for (genvar p = 0; p < NP; p++) begin : g_cache
    recip_sched_centry #(.DW(DW), .QW(QW)) u_ent (
      .clk48 (clk48),
      .rst_n (rst_n),
      .wr    ((state == DONE) && (owner == 1'(p))),
      .wden  (den_q),
      .wres  (result),
      .vld   (c_vld[p]),
      .den   (c_den[p]),
      .res   (c_res[p])
    );
  end

  // The entry for the op finishing this cycle is not stored yet; forward it.
  always_comb begin
    byp     = (state == DONE) && (owner == pick) && (den_q == den_sel);
    hit     = byp || (c_vld[pick] && (c_den[pick] == den_sel));
    hit_res = byp ? result : c_res[pick];
  end
`else
  assign hit     = 1'b0;
  assign hit_res = SAT;
`endif

  always_comb begin
    state_nx = state;
    fin_res  = sat_res;
    unique case (state)
      IDLE, DONE: begin
        if (gnt_vld) state_nx = (zero_den || hit) ? DONE : RUN;
        else         state_nx = IDLE;
        fin_res = zero_den ? SAT : hit_res;
      end
      RUN: if (cnt == 5'd16) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      owner  <= 1'b0;
      den_q  <= '0;
      done   <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      done  <= '0;
      if (gnt_vld) begin
        last  <= pick;
        owner <= pick;
        den_q <= den_sel;
        cnt   <= '0;
        quo   <= '0;
        rem   <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        quo <= quo_nx;
        rem <= rem_nx;
      end
      if (state_nx == DONE) begin
        done   <= owner_nx ? 2'b10 : 2'b01;
        result <= fin_res;
      end
    end
  end
endmodule

// File: tb/tb_recip_sched.sv
// Bench for recip_sched: directed table, hand sequences and random traffic against
// a cycle-slot scoreboard model. Define RECIP_SCHED_CACHE_EN to also exercise the cache.
module tb_recip_sched;
  localparam int QW = 11;
  localparam int DW = 10;

  logic          clk48 = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] denom0 = '0, denom1 = '0;
  logic [1:0]    ack, done;
  logic [QW-1:0] result;
  logic          busy;

  recip_sched dut (
    .clk48(clk48), .rst_n(rst_n), .req(req), .denom0(denom0), .denom1(denom1),
    .ack(ack), .done(done), .result(result), .busy(busy)
  );

  always #5 clk48 = ~clk48;

  int nerr = 0, nchk = 0, cyc_n = 0;

  typedef struct { int cyc; int port; int den; int res; } exp_t;
  exp_t sb[$];
  int ready_at, m_last, m_res, last_grant, m_lat;
  int cv[2], cd[2], cr[2];
  int obs_ack, obs_done, obs_res;

  typedef struct { int port; int den; int lat; int res; } vec_t;
  vec_t tbl[$];

  function automatic int ref_q(input int d);
    if (d == 0) return 2047;
    return (65536 / d > 2047) ? 2047 : 65536 / d;
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc_n, a, e);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    ready_at = 0; m_last = 1; m_res = 0; last_grant = -100; m_lat = 0; cyc_n = 0;
    for (int i = 0; i < 2; i++) begin cv[i] = 0; cd[i] = 0; cr[i] = 0; end
  endtask

  // One clock cycle: drive, evaluate the model for this cycle, compare.
  task automatic step(input logic [1:0] r, input int d0, input int d1);
    int ed, ea, eb, p, d, lat;
    @(negedge clk48);
    req = r; denom0 = DW'(d0); denom1 = DW'(d1);
    #1;
    ed = 0; ea = 0;
    if (sb.size() != 0 && sb[0].cyc == cyc_n) begin
      ed = 1 << sb[0].port;
      m_res = sb[0].res;
`ifdef RECIP_SCHED_CACHE_EN
      cv[sb[0].port] = 1; cd[sb[0].port] = sb[0].den; cr[sb[0].port] = sb[0].res;
`endif
      void'(sb.pop_front());
    end
    if (cyc_n >= ready_at && r != 2'b00) begin
      if (r == 2'b11) p = 1 - m_last;
      else            p = r[1] ? 1 : 0;
      d = p ? d1 : d0;
      lat = (d == 0) ? 1 : 18;
      if (cv[p] != 0 && cd[p] == d) lat = 1;
      ea = 1 << p;
      sb.push_back('{cyc_n + lat, p, d, ref_q(d)});
      ready_at = cyc_n + lat; m_last = p; last_grant = cyc_n; m_lat = lat;
    end
    eb = (cyc_n > last_grant && cyc_n < ready_at && m_lat == 18) ? 1 : 0;
    chk("ack", int'(ack), ea);
    chk("done", int'(done), ed);
    chk("result", int'(result), m_res);
    chk("busy", int'(busy), eb);
    obs_ack = int'(ack); obs_done = int'(done); obs_res = int'(result);
    cyc_n++;
  endtask

  task automatic single(input int p, input int d, input int lat, input int res, input string nm);
    int k;
    logic [1:0] r;
    r = (p == 1) ? 2'b10 : 2'b01;
    step(r, d, d);
    chk({nm, "_ack"}, obs_ack, int'(r));
    k = 0;
    do begin step(2'b00, d, d); k++; end while (obs_done == 0 && k < 40);
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_res"}, obs_res, res);
    chk({nm, "_port"}, obs_done, int'(r));
  endtask

  initial begin
    int acks[$], ackc[$], donec[$];
    int pend[2], pd[2];
    logic [1:0] r;

    // Reset state with both requests already pending
    req = 2'b11; denom0 = 10'd33; denom1 = 10'd1023;
    #2;
    chk("rst_ack", int'(ack), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk48); @(posedge clk48); #2;
    rst_n = 1'b1;
    model_reset();

    // Tie from reset, port 0 first, back-to-back grant in its DONE cycle
    step(2'b11, 33, 1023);
    chk("s2_ack0", obs_ack, 1);
    for (int i = 0; i < 17; i++) step(2'b10, 33, 1023);
    step(2'b10, 33, 1023);
    chk("s2_done0", obs_done, 1);
    chk("s2_res0", obs_res, 1985);
    chk("s2_ack1", obs_ack, 2);
    for (int i = 0; i < 17; i++) step(2'b00, 33, 1023);
    step(2'b00, 33, 1023);
    chk("s2_done1", obs_done, 2);
    chk("s2_res1", obs_res, 64);

    tbl = '{'{0, 240, 18, 273}, '{0, 1, 18, 2047}, '{0, 0, 1, 2047}, '{1, 32, 18, 2047},
            '{1, 33, 18, 1985}, '{0, 1023, 18, 64}, '{1, 64, 18, 1024}, '{0, 1000, 18, 65},
            '{1, 0, 1, 2047}, '{0, 31, 18, 2047}, '{0, 37, 18, 1771}};
    foreach (tbl[i]) single(tbl[i].port, tbl[i].den, tbl[i].lat, tbl[i].res, $sformatf("tbl%0d", i));

`ifdef RECIP_SCHED_CACHE_EN
    single(1, 240, 18, 273, "c_first");
    single(1, 240, 1, 273, "c_hit");
    single(1, 241, 18, 271, "c_miss");
`endif

    // Reset in the middle of RUN discards the op
    step(2'b01, 240, 0);
    for (int i = 0; i < 9; i++) step(2'b00, 240, 0);
    req = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(posedge clk48); #2;
    rst_n = 1'b1;
    model_reset();

    // Continuous tie: alternating grants, fixed ack-to-done latency
    for (int i = 0; i < 80; i++) begin
      step(2'b11, 100, 200);
      if (obs_ack != 0) begin acks.push_back(obs_ack); ackc.push_back(cyc_n - 1); end
      if (obs_done != 0) donec.push_back(cyc_n - 1);
    end
    chk("rr_nack", (acks.size() >= 4 && donec.size() >= 4) ? 1 : 0, 1);
    if (acks.size() >= 4 && donec.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_ack%0d", i), acks[i], (i % 2 == 0) ? 1 : 2);
`ifdef RECIP_SCHED_CACHE_EN
        chk($sformatf("rr_lat%0d", i), donec[i] - ackc[i], (i < 2) ? 18 : 1);
`else
        chk($sformatf("rr_lat%0d", i), donec[i] - ackc[i], 18);
`endif
      end
    for (int i = 0; i < 20; i++) step(2'b00, 0, 0);

    // Random requesters: hold until ack, occasional drop or denom change
    for (int p = 0; p < 2; p++) begin pend[p] = 0; pd[p] = 0; end
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[p] = 1;
            case ($urandom_range(0, 7))
              0:       pd[p] = 0;
              1, 2:    pd[p] = $urandom_range(1, 40);
              3:       pd[p] = 240;
              default: pd[p] = $urandom_range(0, 1023);
            endcase
          end
        end else begin
          if ($urandom_range(0, 31) == 0) pend[p] = 0;
          if ($urandom_range(0, 15) == 0) pd[p] = $urandom_range(0, 1023);
        end
      end
      r = {pend[1] != 0, pend[0] != 0};
      step(r, pd[0], pd[1]);
      for (int p = 0; p < 2; p++) if (obs_ack[p]) pend[p] = 0;
    end
    for (int i = 0; i < 40; i++) step(2'b00, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
